hs_load_sequencer: RTL
======================

HS_LOAD_SEQUENCER -- requirements
Module: hs_load_sequencer

Interface
REQ-001 Parameter HISCORE_SLOT_ID, 16'd2: dataslot ID of the hiscore NVRAM file.
REQ-002 Parameter HISCORE_BRIDGE_ADDR, 32'h10001620: bridge address the host writes the file to.
REQ-003 Parameter HISCORE_SIZE, 32'h50: byte length requested from the host.
REQ-004 Parameter SETTLE_CYCLES, 16'd1024: delay after signature before requesting the load.
REQ-005 Parameter TIMEOUT_CYCLES, 32'd50_000_000: maximum wait for ack plus done.
REQ-006 Parameter MAX_RETRIES, 2'd2: extra attempts after a failed load (only with HS_LOAD_RETRY_EN).
REQ-007 clk  in  1  single bridge-domain clock; every flop in the block uses it.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 slot_addr_found  in  1  level; hiscore slot entry seen in the dataslot table.
REQ-010 slot_size_zero  in  1  level; host reported zero-length or missing NVRAM file.
REQ-011 hs_signature_found  in  1  level, already synchronised to clk; game hiscore RAM initialised.
REQ-012 target_req  out  1  level request to host: load a dataslot to bridge memory.
REQ-013 target_slot_id  out  16  slot ID for the request.
REQ-014 target_bridge_addr  out  32  destination address for the request.
REQ-015 target_length  out  32  byte count for the request.
REQ-016 target_ack  in  1  one-cycle pulse; host accepted the request.
REQ-017 target_done  in  1  one-cycle pulse; host finished the transfer.
REQ-018 target_err  in  3  status valid with target_done; 0 = OK.
REQ-019 busy  out  1  high in SETTLE, REQUEST and WAIT_DONE.
REQ-020 load_done  out  1  sticky; NVRAM data loaded successfully.
REQ-021 load_skipped  out  1  sticky; no file, so no load was attempted.
REQ-022 load_failed  out  1  sticky; load abandoned after an error or timeout.

Function
REQ-023 The FSM SHALL have the states WAIT_SLOT, WAIT_SIGNATURE, SETTLE, REQUEST, WAIT_DONE, DONE, SKIPPED and FAILED.
REQ-024 WAIT_SLOT SHALL go to WAIT_SIGNATURE when slot_addr_found=1.
REQ-025 WAIT_SIGNATURE SHALL go to SKIPPED when slot_size_zero=1; otherwise it SHALL go to SETTLE when hs_signature_found=1.
REQ-026 If slot_size_zero=1 and hs_signature_found=1 in the same cycle, SKIPPED SHALL win.
REQ-027 SETTLE SHALL count SETTLE_CYCLES clk cycles with a 16-bit counter, then enter REQUEST.
- SETTLE_CYCLES=0 enters REQUEST on the next cycle.
REQ-028 Entering REQUEST SHALL set target_req=1 on the next edge, with target_slot_id, target_bridge_addr and target_length equal to the parameters.
REQ-029 All target_* outputs SHALL be registered and stable while target_req=1.
REQ-030 target_req SHALL deassert on the edge after target_ack=1 is sampled, and the FSM SHALL enter WAIT_DONE.
REQ-031 target_done arriving in the same cycle as target_ack SHALL be treated as ack followed by done.
REQ-032 In WAIT_DONE, target_done with target_err=0 SHALL go to DONE; target_done with target_err!=0 SHALL be an error.
REQ-033 A 32-bit timeout counter SHALL clear on entry to REQUEST and count in REQUEST and WAIT_DONE.
- Reaching TIMEOUT_CYCLES-1 SHALL be an error, and SHALL drop target_req on the next edge.
REQ-034 An error SHALL go to FAILED unless a retry is permitted (REQ-041).
REQ-035 DONE, SKIPPED and FAILED SHALL be terminal until reset; each sets its sticky flag on the entry edge.
- At most one sticky flag SHALL ever be high.
REQ-036 hs_signature_found deasserting after SETTLE is entered SHALL NOT abort the sequence.
REQ-037 target_ack or target_done outside REQUEST/WAIT_DONE SHALL be ignored.

Reset
REQ-038 reset_n=0 SHALL asynchronously force state WAIT_SLOT and clear all counters.
- Reset SHALL force target_req, busy, load_done, load_skipped and load_failed to 0, and target_slot_id, target_bridge_addr and target_length to 0.
REQ-039 Reset asserted mid-request SHALL drop target_req immediately, with no completion required from the host.
REQ-040 Reset SHALL be released synchronously: the first FSM transition occurs on the second clk edge after reset_n rises.

Configuration
REQ-041 With macro HS_LOAD_RETRY_EN defined, an error with fewer than MAX_RETRIES retries used SHALL increment a 2-bit retry count, reload the settle counter and return to SETTLE.
- Only the error after the last permitted retry SHALL enter FAILED.
REQ-042 With HS_LOAD_RETRY_EN undefined, there SHALL be no retry logic and every error SHALL enter FAILED.

Verification
REQ-043 Scenario 1: slot_addr_found, size nonzero, signature, ack at cycle 3 of REQUEST, done with err 0 five cycles later -> target_req high for exactly 3 cycles carrying 2/0x10001620/0x50; load_done=1; busy=0.
REQ-044 Scenario 2: slot_size_zero=1 and signature in the same cycle -> load_skipped=1; target_req never asserted.
REQ-045 Scenario 3: target_done with target_err=3'd1 -> with the macro, 3 requests in total, then load_failed=1; without the macro, 1 request, then load_failed=1.
REQ-046 Scenario 4: TIMEOUT_CYCLES=100 and no ack -> target_req drops after 100 cycles; failure or retry per REQ-041/042.
REQ-047 Scenario 5: reset_n pulsed low while target_req=1 -> target_req=0 with no clock edge needed; FSM restarts in WAIT_SLOT.
REQ-048 Scenario 6: target_ack and target_done with err 0 in the same cycle -> load_done=1 two edges later.

Source files
------------

// File: rtl/hs_load_sequencer.sv
// Hiscore NVRAM load sequencer: waits for slot + signature, asks the host to load the file.
// Optional retry of failed loads when HS_LOAD_RETRY_EN is defined.
module hs_load_sequencer #(
  parameter logic [15:0] HISCORE_SLOT_ID     = 16'd2,
  parameter logic [31:0] HISCORE_BRIDGE_ADDR = 32'h10001620,
  parameter logic [31:0] HISCORE_SIZE        = 32'h50,
  parameter logic [15:0] SETTLE_CYCLES       = 16'd1024,
  parameter logic [31:0] TIMEOUT_CYCLES      = 32'd50_000_000,
  parameter logic [1:0]  MAX_RETRIES         = 2'd2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        slot_addr_found,
  input  logic        slot_size_zero,
  input  logic        hs_signature_found,
  output logic        target_req,
  output logic [15:0] target_slot_id,
  output logic [31:0] target_bridge_addr,
  output logic [31:0] target_length,
  input  logic        target_ack,
  input  logic        target_done,
  input  logic [2:0]  target_err,
  output logic        busy,
  output logic        load_done,
  output logic        load_skipped,
  output logic        load_failed
);

  typedef enum logic [2:0] {
    S_WAIT_SLOT, S_WAIT_SIG, S_SETTLE, S_REQUEST,
    S_WAIT_DONE, S_DONE, S_SKIPPED, S_FAILED
  } state_e;

  state_e      state_q;
  logic        run_q;
  logic [15:0] settle_cnt_q;
  logic [31:0] to_cnt_q;
  logic        done_pend_q;
  logic [2:0]  err_pend_q;
  logic        req_q, busy_q, done_q, skip_q, fail_q;
  logic [15:0] slot_q;
  logic [31:0] addr_q, len_q;
`ifdef HS_LOAD_RETRY_EN
  logic [1:0]  retry_q;
`endif

  logic       done_now, timeout_hit, err_evt;
  logic [2:0] err_now;

  // A done seen together with ack is replayed in the first WAIT_DONE cycle.
  always_comb begin
    done_now    = done_pend_q | target_done;
    err_now     = done_pend_q ? err_pend_q : target_err;
    timeout_hit = (to_cnt_q >= (TIMEOUT_CYCLES - 32'd1));
    err_evt     = 1'b0;
    case (state_q)
      S_REQUEST:   err_evt = !target_ack && timeout_hit;
      S_WAIT_DONE: err_evt = done_now ? (err_now != 3'd0) : timeout_hit;
      default:     err_evt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_WAIT_SLOT;
      run_q        <= 1'b0;
      settle_cnt_q <= '0;
      to_cnt_q     <= '0;
      done_pend_q  <= 1'b0;
      err_pend_q   <= '0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      skip_q       <= 1'b0;
      fail_q       <= 1'b0;
      slot_q       <= '0;
      addr_q       <= '0;
      len_q        <= '0;
`ifdef HS_LOAD_RETRY_EN
      retry_q      <= '0;
`endif
    end else begin
      // First edge after release only arms the FSM.
      run_q <= 1'b1;
      if (run_q) begin
        case (state_q)
          S_WAIT_SLOT: if (slot_addr_found) state_q <= S_WAIT_SIG;
          S_WAIT_SIG: begin
            if (slot_size_zero) begin
              state_q <= S_SKIPPED;
              skip_q  <= 1'b1;
            end else if (hs_signature_found) begin
              state_q      <= S_SETTLE;
              settle_cnt_q <= SETTLE_CYCLES;
              busy_q       <= 1'b1;
            end
          end
          S_SETTLE: begin
            if (settle_cnt_q == 16'd0) begin
              state_q  <= S_REQUEST;
              to_cnt_q <= '0;
              req_q    <= 1'b1;
              slot_q   <= HISCORE_SLOT_ID;
              addr_q   <= HISCORE_BRIDGE_ADDR;
              len_q    <= HISCORE_SIZE;
            end else begin
              settle_cnt_q <= settle_cnt_q - 16'd1;
            end
          end
          S_REQUEST: begin
            to_cnt_q <= to_cnt_q + 32'd1;
            if (target_ack) begin
              state_q     <= S_WAIT_DONE;
              req_q       <= 1'b0;
              done_pend_q <= target_done;
              err_pend_q  <= target_err;
            end
          end
          S_WAIT_DONE: begin
            to_cnt_q    <= to_cnt_q + 32'd1;
            done_pend_q <= 1'b0;
            if (done_now && err_now == 3'd0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= state_q;
        endcase

        if (err_evt) begin
          req_q       <= 1'b0;
          done_pend_q <= 1'b0;
`ifdef HS_LOAD_RETRY_EN
          if (retry_q < MAX_RETRIES) begin
            retry_q      <= retry_q + 2'd1;
            settle_cnt_q <= SETTLE_CYCLES;
            state_q      <= S_SETTLE;
          end else begin
            state_q <= S_FAILED;
            busy_q  <= 1'b0;
            fail_q  <= 1'b1;
          end
`else
          state_q <= S_FAILED;
          busy_q  <= 1'b0;
          fail_q  <= 1'b1;
`endif
        end
      end
    end
  end

  assign target_req         = req_q;
  assign target_slot_id     = slot_q;
  assign target_bridge_addr = addr_q;
  assign target_length      = len_q;
  assign busy               = busy_q;
  assign load_done          = done_q;
  assign load_skipped       = skip_q;
  assign load_failed        = fail_q;

endmodule
